// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DefaultW = 4;

  // 2'b11 is unused and falls back to StIdle in the FSM.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned W = DefaultW
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  always_comb begin
    d_o    = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, behind a start/busy/done handshake.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned W  = DefaultW,
  parameter int unsigned CW = $clog2(W)
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  state_e         state_q;
  logic [W-1:0]   a_sh_q;
  logic [W-1:0]   b_sh_q;
  logic [W-1:0]   r_sh_q;
  logic [W-1:0]   r_sh_nxt;
  logic [W-1:0]   d_q;
  logic [CW-1:0]  cnt_q;
  logic           brw_q;
  logic           bout_q;
  logic           busy_q;
  logic           done_q;
  logic           dbit;
  logic           nb;

  full_subtractor u_fs (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (brw_q),
    .d_o    (dbit),
    .bout_o (nb)
  );

  // New difference bit enters at the MSB; after W shifts bit 0 sits at d[0].
  always_comb begin
    r_sh_nxt = (r_sh_q >> 1) | {dbit, {(W-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            brw_q   <= bus.bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          r_sh_q <= r_sh_nxt;
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          brw_q  <= nb;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            d_q     <= r_sh_nxt;
            bout_q  <= nb;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: arithmetic reference model plus directed and random stimulus.
module tb_serial_subtractor;

  localparam int unsigned W     = 4;
  localparam int          NCOMB = 1 << (2 * W + 1);

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.W(W)) sif ();

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  // Reference model: edges elapsed since accept, result computed as plain integer arithmetic.
  int           m_ph = 0;
  logic [W:0]   m_pend = '0;
  logic [W-1:0] m_d = '0;
  logic         m_bout = 1'b0;
  logic         m_done = 1'b0;
  int           diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   = 0;
      m_pend = '0;
      m_d    = '0;
      m_bout = 1'b0;
      m_done = 1'b0;
    end else if (m_ph == 0) begin
      if (sif.start === 1'b1) begin
        diff   = int'(sif.a) - int'(sif.b) - int'(sif.bin);
        m_pend = diff[W:0];
        m_ph   = 1;
      end
    end else begin
      m_ph = m_ph + 1;
      if (m_ph == W + 1) begin
        m_d    = m_pend[W-1:0];
        m_bout = m_pend[W];
        m_done = 1'b1;
      end else if (m_ph == W + 2) begin
        m_ph   = 0;
        m_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (sif.busy !== (m_ph != 0) || sif.done !== m_done || sif.d !== m_d ||
        sif.bout !== m_bout) begin
      n_err++;
      $display("FAIL cycle t=%0t: got busy=%b done=%b d=%h bout=%b, expected busy=%b done=%b d=%h bout=%b",
               $time, sif.busy, sif.done, sif.d, sif.bout, (m_ph != 0), m_done, m_d, m_bout);
    end
    if (sif.done === 1'b1) done_seen++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Launch one op from idle and check latency, hold and result against literals.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic [W-1:0] prev_d, input logic prev_bout,
                        input logic [W-1:0] exp_d, input logic exp_bout);
    sif.a = a; sif.b = b; sif.bin = bin; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.a = W'($urandom); sif.b = W'($urandom); sif.bin = 1'($urandom);
    check({name, "_busy"}, 32'(sif.busy), 32'd1);
    repeat (W - 1) tick();
    check({name, "_hold_d"}, 32'(sif.d), 32'(prev_d));
    check({name, "_hold_bout"}, 32'(sif.bout), 32'(prev_bout));
    check({name, "_early_done"}, 32'(sif.done), 32'd0);
    tick();
    check({name, "_done"}, 32'(sif.done), 32'd1);
    check({name, "_d"}, 32'(sif.d), 32'(exp_d));
    check({name, "_bout"}, 32'(sif.bout), 32'(exp_bout));
    check({name, "_model_d"}, 32'(m_d), 32'(exp_d));
    tick();
    check({name, "_idle_busy"}, 32'(sif.busy), 32'd0);
    check({name, "_idle_done"}, 32'(sif.done), 32'd0);
  endtask

  initial begin
    int d0;
    int idx;
    int cyc;
    logic [2*W:0] v;

    rst_n = 1'b0;
    sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0;
    repeat (3) tick();
    check("reset_busy", 32'(sif.busy), 32'd0);
    check("reset_done", 32'(sif.done), 32'd0);
    check("reset_d", 32'(sif.d), 32'd0);
    check("reset_bout", 32'(sif.bout), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("basic", 4'b1101, 4'b1011, 1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0);
    run_op("under1", 4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, 4'b1111, 1'b1);
    run_op("under2", 4'b0101, 4'b0101, 1'b1, 4'b1111, 1'b1, 4'b1111, 1'b1);

    // Start re-issued at E2 and during DONE must be dropped.
    d0 = done_seen;
    sif.a = 4'b1101; sif.b = 4'b1011; sif.bin = 1'b1; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    tick();
    sif.a = 4'b1111; sif.b = 4'b0000; sif.bin = 1'b0; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    tick();
    tick();
    check("ign_done", 32'(sif.done), 32'd1);
    check("ign_d", 32'(sif.d), 32'h1);
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    check("ign_busy_drop", 32'(sif.busy), 32'd0);
    repeat (W + 2) tick();
    check("ign_one_done", 32'(done_seen - d0), 32'd1);
    check("ign_d_kept", 32'(sif.d), 32'h1);

    run_op("hold", 4'b1000, 4'b0011, 1'b0, 4'b0001, 1'b0, 4'b0101, 1'b0);

    // Asynchronous abort two edges into an operation.
    sif.a = 4'b1111; sif.b = 4'b0001; sif.bin = 1'b0; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(sif.busy), 32'd0);
    check("abort_done", 32'(sif.done), 32'd0);
    check("abort_d", 32'(sif.d), 32'd0);
    check("abort_bout", 32'(sif.bout), 32'd0);
    d0 = done_seen;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (W + 3) tick();
    check("abort_no_done", 32'(done_seen - d0), 32'd0);
    run_op("after_abort", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1111, 1'b1);

    // Random traffic: start toggles freely, operands change every cycle.
    for (int i = 0; i < 400; i++) begin
      sif.start = ($urandom_range(0, 2) == 0);
      sif.a = W'($urandom); sif.b = W'($urandom); sif.bin = 1'($urandom);
      tick();
    end
    sif.start = 1'b0;
    for (int i = 0; i < 20 && m_ph != 0; i++) tick();
    check("rand_settle_busy", 32'(sif.busy), 32'd0);

    // Exhaustive, back-to-back at the earliest accept with start held high.
    d0 = done_seen;
    idx = 0;
    cyc = 0;
    while (cyc < 6 * NCOMB + 50) begin
      if (m_ph == 0) begin
        if (idx < NCOMB) begin
          v = (2 * W + 1)'(idx);
          {sif.a, sif.b, sif.bin} = v;
          sif.start = 1'b1;
          idx++;
        end else begin
          break;
        end
      end
      tick();
      cyc++;
    end
    sif.start = 1'b0;
    check("exh_all_issued", 32'(idx), 32'(NCOMB));
    check("exh_done_count", 32'(done_seen - d0), 32'(NCOMB));
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
